// File: rtl/reg_result_checker_if.sv
// Handshake/bus bundle for reg_result_checker: arm/config, snooped RF write port,
// halt, readback select and status. master = stimulus side, slave = checker side.
interface reg_result_checker_if #(
    parameter int XLEN    = 32,
    parameter int NUM_CHK = 4,
    parameter int TMO_W   = 16
);
    localparam int SEL_W = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1;

    logic                    start;
    logic [TMO_W-1:0]        timeout_cycles;
    logic [NUM_CHK*5-1:0]    chk_addr;
    logic [NUM_CHK*XLEN-1:0] chk_exp;
    logic                    rf_we;
    logic [4:0]              rf_waddr;
    logic [XLEN-1:0]         rf_wdata;
    logic                    halt;
    logic [SEL_W-1:0]        obs_sel;
    logic [XLEN-1:0]         obs_data;
    logic                    busy;
    logic                    done;
    logic                    pass;
    logic                    timed_out;
    logic [NUM_CHK-1:0]      fail_mask;

    modport master (
        output start, timeout_cycles, chk_addr, chk_exp,
        output rf_we, rf_waddr, rf_wdata, halt, obs_sel,
        input  obs_data, busy, done, pass, timed_out, fail_mask
    );

    modport slave (
        input  start, timeout_cycles, chk_addr, chk_exp,
        input  rf_we, rf_waddr, rf_wdata, halt, obs_sel,
        output obs_data, busy, done, pass, timed_out, fail_mask
    );
endinterface

// File: rtl/reg_result_checker.sv
// Register result checker: snoops core RF writes into per-channel shadows while
// armed, compares against expected values on halt or watchdog expiry.
// Ports: clock, reset_ (async, active-high), bus (reg_result_checker_if.slave).
module reg_result_checker #(
    parameter int XLEN    = 32,
    parameter int NUM_CHK = 4,
    parameter int TMO_W   = 16
) (
    input logic                  clock,
    input logic                  reset_,
    reg_result_checker_if.slave  bus
);
    localparam int SEL_W = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COMPARE,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [4:0]         addr_q [NUM_CHK];
    logic [XLEN-1:0]    exp_q  [NUM_CHK];
    logic [XLEN-1:0]    shadow [NUM_CHK];
    logic [NUM_CHK-1:0] written;
    logic [NUM_CHK-1:0] fail_q;
    logic               tmo_q;
    logic [TMO_W-1:0]   cnt;

    logic arm;
    logic expire;

    // Counter only reaches 1 when a nonzero length was loaded; halt has priority.
    always_comb begin
        arm    = ((state == IDLE) || (state == DONE)) && bus.start;
        expire = (state == ARMED) && (cnt == TMO_W'(1)) && !bus.halt;
    end

    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = ARMED;
            ARMED:   if (bus.halt || expire) state_nxt = COMPARE;
            COMPARE: state_nxt = DONE;
            DONE:    if (bus.start) state_nxt = ARMED;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            for (int i = 0; i < NUM_CHK; i++) begin
                addr_q[i] <= '0;
                exp_q[i]  <= '0;
                shadow[i] <= '0;
            end
            written <= '0;
            fail_q  <= '0;
            tmo_q   <= 1'b0;
            cnt     <= '0;
        end else if (arm) begin
            for (int i = 0; i < NUM_CHK; i++) begin
                addr_q[i] <= bus.chk_addr[5*i +: 5];
                exp_q[i]  <= bus.chk_exp[XLEN*i +: XLEN];
                shadow[i] <= '0;
            end
            written <= '0;
            fail_q  <= '0;
            tmo_q   <= 1'b0;
            cnt     <= bus.timeout_cycles;
        end else if (state == ARMED) begin
            if (cnt != '0) cnt <= cnt - TMO_W'(1);
            if (expire) tmo_q <= 1'b1;
            // Every channel aliasing the written register updates; x0 never does.
            for (int i = 0; i < NUM_CHK; i++) begin
                if (bus.rf_we && (bus.rf_waddr != 5'd0) &&
                    (bus.rf_waddr == addr_q[i])) begin
                    shadow[i]  <= bus.rf_wdata;
                    written[i] <= 1'b1;
                end
            end
        end else if (state == COMPARE) begin
            // An x0 channel counts as written with a fixed zero shadow.
            for (int i = 0; i < NUM_CHK; i++) begin
                fail_q[i] <= !(written[i] || (addr_q[i] == 5'd0)) ||
                             (shadow[i] != exp_q[i]);
            end
        end
    end

    always_comb begin
        bus.busy      = (state == ARMED) || (state == COMPARE);
        bus.done      = (state == DONE);
        bus.pass      = (state == DONE) && (fail_q == '0) && !tmo_q;
        bus.timed_out = tmo_q;
        bus.fail_mask = fail_q;
    end

    always_comb begin
        bus.obs_data = '0;
        if (32'(bus.obs_sel) < NUM_CHK) bus.obs_data = shadow[bus.obs_sel];
    end
endmodule

// File: tb/tb_reg_result_checker.sv
// Scenario bench for reg_result_checker: a small reference model predicts
// the comparison result, which is queued on halt/timeout and checked at done.
module tb_reg_result_checker;
    localparam int XLEN    = 32;
    localparam int NUM_CHK = 4;
    localparam int TMO_W   = 16;

    logic clock  = 1'b0;
    logic reset_ = 1'b1;

    always #5 clock = ~clock;

    reg_result_checker_if #(
        .XLEN(XLEN), .NUM_CHK(NUM_CHK), .TMO_W(TMO_W)
    ) bus ();

    reg_result_checker #(
        .XLEN(XLEN), .NUM_CHK(NUM_CHK), .TMO_W(TMO_W)
    ) dut (
        .clock  (clock),
        .reset_ (reset_),
        .bus    (bus)
    );

    typedef struct packed {
        logic        pass;
        logic [3:0]  mask;
        logic        tmo;
        logic [31:0] obs0;
    } res_t;

    logic [4:0]  m_addr [NUM_CHK];
    logic [31:0] m_exp  [NUM_CHK];
    logic [31:0] m_sh   [NUM_CHK];
    bit          m_wr   [NUM_CHK];
    res_t        sb [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cfg(input logic [4:0] a0, a1, a2, a3,
                           input logic [31:0] e0, e1, e2, e3);
        m_addr[0] = a0; m_addr[1] = a1; m_addr[2] = a2; m_addr[3] = a3;
        m_exp[0]  = e0; m_exp[1]  = e1; m_exp[2]  = e2; m_exp[3]  = e3;
    endtask

    task automatic arm(input logic [TMO_W-1:0] tmo);
        for (int i = 0; i < NUM_CHK; i++) begin
            bus.chk_addr[5*i +: 5]      = m_addr[i];
            bus.chk_exp[XLEN*i +: XLEN] = m_exp[i];
            m_sh[i] = '0;
            m_wr[i] = 1'b0;
        end
        bus.timeout_cycles = tmo;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input bit h);
        bus.rf_we    = 1'b1;
        bus.rf_waddr = a;
        bus.rf_wdata = d;
        bus.halt     = h;
        tick();
        bus.rf_we = 1'b0;
        bus.halt  = 1'b0;
        for (int i = 0; i < NUM_CHK; i++) begin
            if (a != 5'd0 && m_addr[i] == a) begin
                m_sh[i] = d;
                m_wr[i] = 1'b1;
            end
        end
    endtask

    task automatic halt_only();
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
    endtask

    function automatic res_t model_res(input bit tmo);
        res_t r;
        r.mask = '0;
        for (int i = 0; i < NUM_CHK; i++)
            r.mask[i] = !(m_wr[i] || m_addr[i] == 5'd0) || (m_sh[i] != m_exp[i]);
        r.tmo  = tmo;
        r.pass = (r.mask == 4'd0) && !tmo;
        r.obs0 = m_sh[0];
        return r;
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] st;
        bus.start = 0; bus.timeout_cycles = 0; bus.chk_addr = 0; bus.chk_exp = 0;
        bus.rf_we = 0; bus.rf_waddr = 0; bus.rf_wdata = 0; bus.halt = 0;
        bus.obs_sel = 0;
        reset_ = 1'b1;
        tick(); tick();
        st = {bus.busy, bus.done, bus.pass, bus.timed_out, bus.fail_mask};
        n_checks++;
        if (st !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_status: got %h want 00", st);
        end
        reset_ = 1'b0;
        tick();
        wr(5'd2, 32'h19, 1'b0);
        for (int k = 0; k < NUM_CHK; k++) begin
            bus.obs_sel = 2'(k);
            #1;
            n_checks++;
            if (bus.obs_data !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_obs%0d: got %h want 0", k, bus.obs_data);
            end
        end
        bus.obs_sel = 0;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_basic();
        res_t got, want;
        set_cfg(5'd2, 5'd0, 5'd0, 5'd0, 32'h19, 32'h0, 32'h0, 32'h0);
        arm('0);
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            n_fail++;
            $display("FAIL armed_busy: got %b want 10", {bus.busy, bus.done});
        end
        wr(5'd2, 32'h19, 1'b0);
        halt_only();
        sb.push_back(model_res(1'b0));
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            n_fail++;
            $display("FAIL lat_t1: got %b want 10", {bus.busy, bus.done});
        end
        tick();
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b01) begin
            n_fail++;
            $display("FAIL lat_t2: got %b want 01", {bus.busy, bus.done});
        end
        got  = {bus.pass, bus.fail_mask, bus.timed_out, bus.obs_data};
        want = sb.pop_front();
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL basic: got %h want %h", got, want);
        end
    endtask

    task automatic test_last_write();
        res_t got, want;
        int n;
        arm('0);
        wr(5'd2, 32'h18, 1'b0);
        wr(5'd2, 32'h19, 1'b0);
        bus.chk_exp = '1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        halt_only();
        sb.push_back(model_res(1'b0));
        wait_done(n);
        got  = {bus.pass, bus.fail_mask, bus.timed_out, bus.obs_data};
        want = sb.pop_front();
        n_checks++;
        if (n != 1 || got !== want) begin
            n_fail++;
            $display("FAIL last_wins: got %h want %h (lat %0d)", got, want, n);
        end
        arm('0);
        wr(5'd2, 32'h19, 1'b0);
        wr(5'd2, 32'h18, 1'b0);
        halt_only();
        sb.push_back(model_res(1'b0));
        wait_done(n);
        got  = {bus.pass, bus.fail_mask, bus.timed_out, bus.obs_data};
        want = sb.pop_front();
        n_checks++;
        if (n != 1 || got !== want) begin
            n_fail++;
            $display("FAIL last_wrong: got %h want %h (lat %0d)", got, want, n);
        end
    endtask

    task automatic test_unwritten();
        res_t got, want;
        int n;
        set_cfg(5'd2, 5'd5, 5'd0, 5'd0, 32'h19, 32'h7, 32'h0, 32'h0);
        arm('0);
        wr(5'd2, 32'h19, 1'b0);
        wr(5'd0, 32'h55, 1'b0);
        halt_only();
        sb.push_back(model_res(1'b0));
        wait_done(n);
        got  = {bus.pass, bus.fail_mask, bus.timed_out, bus.obs_data};
        want = sb.pop_front();
        n_checks++;
        if (n != 1 || got !== want) begin
            n_fail++;
            $display("FAIL unwritten: got %h want %h (lat %0d)", got, want, n);
        end
        bus.obs_sel = 2'd2;
        #1;
        n_checks++;
        if (bus.obs_data !== m_sh[2]) begin
            n_fail++;
            $display("FAIL x0_shadow: got %h want %h", bus.obs_data, m_sh[2]);
        end
        bus.obs_sel = 0;
    endtask

    task automatic test_full_width();
        res_t got, want;
        int n;
        set_cfg(5'd9, 5'd2, 5'd9, 5'd31,
                32'hA, 32'h19, 32'hA, 32'h8000_0019);
        arm('0);
        wr(5'd9, 32'hA, 1'b0);
        wr(5'd2, 32'h19, 1'b0);
        wr(5'd31, 32'h0000_0019, 1'b0);
        halt_only();
        sb.push_back(model_res(1'b0));
        wait_done(n);
        got  = {bus.pass, bus.fail_mask, bus.timed_out, bus.obs_data};
        want = sb.pop_front();
        n_checks++;
        if (n != 1 || got !== want) begin
            n_fail++;
            $display("FAIL full_width: got %h want %h (lat %0d)", got, want, n);
        end
        for (int k = 1; k < NUM_CHK; k++) begin
            bus.obs_sel = 2'(k);
            #1;
            n_checks++;
            if (bus.obs_data !== m_sh[k]) begin
                n_fail++;
                $display("FAIL obs%0d: got %h want %h", k, bus.obs_data, m_sh[k]);
            end
        end
        bus.obs_sel = 0;
    endtask

    task automatic test_timeout();
        res_t got, want;
        int n;
        set_cfg(5'd2, 5'd0, 5'd0, 5'd0, 32'h19, 32'h0, 32'h0, 32'h0);
        arm(16'd10);
        wr(5'd2, 32'h19, 1'b0);
        sb.push_back(model_res(1'b1));
        wait_done(n);
        n_checks++;
        if (n != 10) begin
            n_fail++;
            $display("FAIL tmo_latency: got %0d want 10", n);
        end
        got  = {bus.pass, bus.fail_mask, bus.timed_out, bus.obs_data};
        want = sb.pop_front();
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL timeout: got %h want %h", got, want);
        end
    endtask

    task automatic test_halt_edges();
        res_t got, want;
        int n;
        arm('0);
        wr(5'd2, 32'h18, 1'b0);
        wr(5'd2, 32'h19, 1'b1);
        sb.push_back(model_res(1'b0));
        wait_done(n);
        got  = {bus.pass, bus.fail_mask, bus.timed_out, bus.obs_data};
        want = sb.pop_front();
        n_checks++;
        if (n != 1 || got !== want) begin
            n_fail++;
            $display("FAIL halt_write: got %h want %h (lat %0d)", got, want, n);
        end
        arm(16'd3);
        tick();
        wr(5'd2, 32'h19, 1'b0);
        halt_only();
        sb.push_back(model_res(1'b0));
        wait_done(n);
        got  = {bus.pass, bus.fail_mask, bus.timed_out, bus.obs_data};
        want = sb.pop_front();
        n_checks++;
        if (n != 1 || got !== want) begin
            n_fail++;
            $display("FAIL halt_tmo: got %h want %h (lat %0d)", got, want, n);
        end
    endtask

    task automatic test_reset_mid();
        res_t got, want;
        int n;
        arm('0);
        wr(5'd2, 32'h19, 1'b0);
        #2;
        reset_ = 1'b1;
        #1;
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset: got %b want 00", {bus.busy, bus.done});
        end
        tick();
        reset_ = 1'b0;
        wr(5'd2, 32'h19, 1'b0);
        n_checks++;
        if ({bus.busy, bus.obs_data} !== 33'h0) begin
            n_fail++;
            $display("FAIL post_reset: got %h want 0", {bus.busy, bus.obs_data});
        end
        arm('0);
        halt_only();
        sb.push_back(model_res(1'b0));
        wait_done(n);
        got  = {bus.pass, bus.fail_mask, bus.timed_out, bus.obs_data};
        want = sb.pop_front();
        n_checks++;
        if (n != 1 || got !== want) begin
            n_fail++;
            $display("FAIL rearm: got %h want %h (lat %0d)", got, want, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_last_write();
        test_unwritten();
        test_full_width();
        test_timeout();
        test_halt_edges();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
